// File: rtl/dport_axi_slave.sv
// AXI4 slave front-end that turns one AXI burst at a time into single-word
// dcache_if-style memory requests, one outstanding request at a time.
module dport_axi_slave (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  output logic        axi_awready_o,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o,
  input  logic        axi_rready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic        mem_cacheable_o,
  output logic [10:0] mem_req_tag_o,
  output logic        mem_invalidate_o,
  output logic        mem_writeback_o,
  output logic        mem_flush_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_data_rd_i,
  input  logic [10:0] mem_resp_tag_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WREQ, S_WACK, S_BRESP, S_RREQ, S_RACK, S_RRESP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_id, r_wstrb, r_mem_wr;
  logic [7:0]  r_len, r_cnt;
  logic [1:0]  r_burst, r_rresp;
  logic        r_err, r_prio_wr, r_mem_rd, r_wready, r_bvalid, r_rvalid, r_rlast;

  logic        w_rd_gnt, w_wr_gnt, w_last, w_wr_skip, w_wr_done, w_rd_done;
  logic        w_mem_rd_nxt, w_wready_nxt, w_bvalid_nxt, w_rvalid_nxt;
  logic [3:0]  w_mem_wr_nxt;
  logic [31:0] w_addr_inc, w_addr_adv, w_wrap_mask;
  logic        w_unused;

  // Round-robin: r_prio_wr is set after a read grant, so a clash goes to write next
  assign w_rd_gnt  = (r_state == S_IDLE) && rst_i && axi_arvalid_i &&
                     (!axi_awvalid_i || !r_prio_wr);
  assign w_wr_gnt  = (r_state == S_IDLE) && rst_i && axi_awvalid_i &&
                     (!axi_arvalid_i || r_prio_wr);
  assign w_last    = (r_cnt == r_len);
  assign w_wr_skip = (r_state == S_WDATA) && axi_wvalid_i && (axi_wstrb_i == 4'h0);
  assign w_wr_done = w_wr_skip || ((r_state == S_WACK) && mem_ack_i);
  assign w_rd_done = (r_state == S_RRESP) && axi_rready_i;

  // WRAP window is (len+1)*4 bytes; legal wrap lengths make {len,2'b11} the offset mask
  assign w_addr_inc  = r_addr + 32'd4;
  assign w_wrap_mask = {22'd0, r_len, 2'b11};
  always_comb begin
    case (r_burst)
      2'b00:   w_addr_adv = r_addr;
      2'b10:   w_addr_adv = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default: w_addr_adv = w_addr_inc;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rd_gnt) w_state_nxt = S_RREQ;
               else if (w_wr_gnt) w_state_nxt = S_WDATA;
      S_WDATA: if (w_wr_skip) w_state_nxt = w_last ? S_BRESP : S_WDATA;
               else if (axi_wvalid_i) w_state_nxt = S_WREQ;
      S_WREQ:  if (mem_accept_i) w_state_nxt = S_WACK;
      S_WACK:  if (mem_ack_i) w_state_nxt = w_last ? S_BRESP : S_WDATA;
      S_BRESP: if (axi_bready_i) w_state_nxt = S_IDLE;
      S_RREQ:  if (mem_accept_i) w_state_nxt = S_RACK;
      S_RACK:  if (mem_ack_i) w_state_nxt = S_RRESP;
      S_RRESP: if (axi_rready_i) w_state_nxt = w_last ? S_IDLE : S_RREQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are loaded from the state being entered
  always_comb begin
    axi_awready_o = w_wr_gnt;
    axi_arready_o = w_rd_gnt;
    w_mem_rd_nxt  = (w_state_nxt == S_RREQ);
    w_mem_wr_nxt  = 4'h0;
    if (w_state_nxt == S_WREQ)
      w_mem_wr_nxt = (r_state == S_WDATA) ? axi_wstrb_i : r_wstrb;
    w_wready_nxt  = (w_state_nxt == S_WDATA);
    w_bvalid_nxt  = (w_state_nxt == S_BRESP);
    w_rvalid_nxt  = (w_state_nxt == S_RRESP);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_rd <= 1'b0;
      r_mem_wr <= 4'h0;
      r_wready <= 1'b0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_mem_rd <= w_mem_rd_nxt;
      r_mem_wr <= w_mem_wr_nxt;
      r_wready <= w_wready_nxt;
      r_bvalid <= w_bvalid_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_id      <= 4'd0;
      r_wstrb   <= 4'd0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
      r_burst   <= 2'd0;
      r_rresp   <= 2'd0;
      r_err     <= 1'b0;
      r_prio_wr <= 1'b0;
      r_rlast   <= 1'b0;
    end else begin
      if (w_rd_gnt || w_wr_gnt) begin
        r_addr    <= w_rd_gnt ? axi_araddr_i  : axi_awaddr_i;
        r_id      <= w_rd_gnt ? axi_arid_i    : axi_awid_i;
        r_len     <= w_rd_gnt ? axi_arlen_i   : axi_awlen_i;
        r_burst   <= w_rd_gnt ? axi_arburst_i : axi_awburst_i;
        r_cnt     <= 8'd0;
        r_prio_wr <= w_rd_gnt;
      end
      if ((r_state == S_WDATA) && axi_wvalid_i) begin
        r_wdata <= axi_wdata_i;
        r_wstrb <= axi_wstrb_i;
      end
      if (w_wr_done || w_rd_done) begin
        r_cnt <= r_cnt + 8'd1;
        if (!w_last) r_addr <= w_addr_adv;
      end
      if ((r_state == S_WACK) && mem_ack_i)
        r_err <= r_err | mem_error_i;
      else if ((r_state == S_BRESP) && axi_bready_i)
        r_err <= 1'b0;
      if ((r_state == S_RACK) && mem_ack_i) begin
        r_rdata <= mem_data_rd_i;
        r_rresp <= mem_error_i ? 2'b10 : 2'b00;
        r_rlast <= w_last;
      end
    end
  end

  assign axi_wready_o     = r_wready;
  assign axi_bvalid_o     = r_bvalid;
  assign axi_bresp_o      = {r_err, 1'b0};
  assign axi_bid_o        = r_id;
  assign axi_rvalid_o     = r_rvalid;
  assign axi_rdata_o      = r_rdata;
  assign axi_rresp_o      = r_rresp;
  assign axi_rid_o        = r_id;
  assign axi_rlast_o      = r_rlast;
  assign mem_addr_o       = {r_addr[31:2], 2'b00};
  assign mem_data_wr_o    = r_wdata;
  assign mem_rd_o         = r_mem_rd;
  assign mem_wr_o         = r_mem_wr;
  assign mem_cacheable_o  = 1'b0;
  assign mem_req_tag_o    = 11'd0;
  assign mem_invalidate_o = 1'b0;
  assign mem_writeback_o  = 1'b0;
  assign mem_flush_o      = 1'b0;

  // Beat count comes only from the latched len; response tags carry nothing here
  assign w_unused = ^{axi_wlast_i, mem_resp_tag_i};

endmodule

// File: tb/tb_dport_axi_slave.sv
// Scoreboard bench for dport_axi_slave: AXI driver tasks plus a memory
// responder that checks every request against queued expectations.
module tb_dport_axi_slave;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        axi_awvalid_i, axi_awready_o, axi_wvalid_i, axi_wlast_i, axi_wready_o;
  logic [31:0] axi_awaddr_i, axi_wdata_i, axi_araddr_i, axi_rdata_o;
  logic [3:0]  axi_awid_i, axi_wstrb_i, axi_bid_o, axi_arid_i, axi_rid_o;
  logic [7:0]  axi_awlen_i, axi_arlen_i;
  logic [1:0]  axi_awburst_i, axi_bresp_o, axi_arburst_i, axi_rresp_o;
  logic        axi_bvalid_o, axi_bready_i, axi_arvalid_i, axi_arready_o;
  logic        axi_rvalid_o, axi_rlast_o, axi_rready_i;
  logic [31:0] mem_addr_o, mem_data_wr_o, mem_data_rd_i;
  logic        mem_rd_o, mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o;
  logic [3:0]  mem_wr_o;
  logic [10:0] mem_req_tag_o, mem_resp_tag_i;
  logic        mem_accept_i, mem_ack_i, mem_error_i;

  typedef struct {logic [31:0] addr; logic rd; logic [3:0] strb; logic [31:0] wdata;
                  logic [31:0] rdata; logic err;} mreq_t;
  typedef struct {logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last;} rbeat_t;
  typedef struct {logic [1:0] resp; logic [3:0] id;} bexp_t;

  mreq_t  mq[$];
  rbeat_t rq[$];
  bexp_t  bq[$];
  mreq_t  m_cur;
  int     n_vec = 0;
  int     n_err = 0;
  logic   hold_ack = 1'b0;
  logic   m_busy, m_seen;
  int     m_stall, m_ack_dly;
  logic [31:0] m_hold_addr;
  logic [3:0]  m_hold_wr;

  dport_axi_slave dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_awvalid_i(axi_awvalid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
    .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i), .axi_awready_o(axi_awready_o),
    .axi_wvalid_i(axi_wvalid_i), .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
    .axi_wlast_i(axi_wlast_i), .axi_wready_o(axi_wready_o),
    .axi_bvalid_o(axi_bvalid_o), .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
    .axi_bready_i(axi_bready_i),
    .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
    .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i), .axi_arready_o(axi_arready_o),
    .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o), .axi_rready_i(axi_rready_i),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_cacheable_o(mem_cacheable_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_invalidate_o(mem_invalidate_o), .mem_writeback_o(mem_writeback_o),
    .mem_flush_o(mem_flush_o), .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
    .mem_error_i(mem_error_i), .mem_data_rd_i(mem_data_rd_i), .mem_resp_tag_i(mem_resp_tag_i)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] nxt_addr(input logic [31:0] a, input logic [7:0] len,
                                           input logic [1:0] b);
    logic [31:0] sz, base;
    case (b)
      2'b00: return a;
      2'b10: begin
        sz   = ({24'd0, len} + 32'd1) * 32'd4;
        base = a - (a % sz);
        return base + ((a - base + 32'd4) % sz);
      end
      default: return a + 32'd4;
    endcase
  endfunction

  // Memory responder: random accept stall, random ack delay, checks each request
  initial begin
    mem_accept_i = 0; mem_ack_i = 0; mem_error_i = 0; mem_data_rd_i = 0; mem_resp_tag_i = 0;
    m_busy = 0; m_seen = 0; m_stall = 0; m_ack_dly = 0;
    forever begin
      @(posedge clk_i); #1;
      mem_accept_i = 0; mem_ack_i = 0; mem_error_i = 0;
      if (!rst_i) begin
        m_busy = 0; m_seen = 0;
      end else if (m_busy) begin
        if (mem_rd_o || mem_wr_o != 4'h0) begin
          n_vec++; n_err++;
          $display("FAIL mem_outstanding: second request rd=%0b wr=%h while busy, required none",
                   mem_rd_o, mem_wr_o);
        end
        if (m_ack_dly > 0) m_ack_dly--;
        else if (!hold_ack) begin
          mem_ack_i = 1; mem_error_i = m_cur.err; mem_data_rd_i = m_cur.rdata; m_busy = 0;
        end
      end else if (mem_rd_o || mem_wr_o != 4'h0) begin
        if (!m_seen) begin
          m_seen = 1; m_stall = $urandom_range(0, 2);
          m_hold_addr = mem_addr_o; m_hold_wr = mem_wr_o;
        end else begin
          n_vec++;
          if (mem_addr_o !== m_hold_addr || mem_wr_o !== m_hold_wr) begin
            n_err++;
            $display("FAIL mem_hold: addr=%h wr=%h, required stable addr=%h wr=%h",
                     mem_addr_o, mem_wr_o, m_hold_addr, m_hold_wr);
          end
        end
        if (m_stall > 0) m_stall--;
        else begin
          m_seen = 0;
          n_vec++;
          if (mq.size() == 0) begin
            n_err++;
            $display("FAIL mem_unexpected: request addr=%h rd=%0b wr=%h, required none",
                     mem_addr_o, mem_rd_o, mem_wr_o);
            m_cur = '{32'd0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0};
          end else begin
            m_cur = mq.pop_front();
            if ({mem_addr_o, mem_rd_o, mem_wr_o} !==
                {m_cur.addr, m_cur.rd, (m_cur.rd ? 4'h0 : m_cur.strb)}) begin
              n_err++;
              $display("FAIL mem_req: addr=%h rd=%0b wr=%h, required addr=%h rd=%0b wr=%h",
                       mem_addr_o, mem_rd_o, mem_wr_o, m_cur.addr, m_cur.rd,
                       (m_cur.rd ? 4'h0 : m_cur.strb));
            end
            if (!m_cur.rd) begin
              n_vec++;
              if (mem_data_wr_o !== m_cur.wdata) begin
                n_err++;
                $display("FAIL mem_wdata: got %h required %h", mem_data_wr_o, m_cur.wdata);
              end
            end
          end
          mem_accept_i = 1; m_busy = 1; m_ack_dly = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [1:0] b);
    int k;
    axi_awaddr_i = a; axi_awid_i = id; axi_awlen_i = len; axi_awburst_i = b;
    axi_awvalid_i = 1; #1;
    k = 0;
    while (!axi_awready_o && k < 100) begin @(posedge clk_i); #1; k++; end
    n_vec++;
    if (!axi_awready_o) begin
      n_err++; $display("FAIL aw_handshake: awready=%0b after %0d cycles, required 1", axi_awready_o, k);
    end
    @(posedge clk_i); #1;
    axi_awvalid_i = 0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [1:0] b);
    int k;
    axi_araddr_i = a; axi_arid_i = id; axi_arlen_i = len; axi_arburst_i = b;
    axi_arvalid_i = 1; #1;
    k = 0;
    while (!axi_arready_o && k < 100) begin @(posedge clk_i); #1; k++; end
    n_vec++;
    if (!axi_arready_o) begin
      n_err++; $display("FAIL ar_handshake: arready=%0b after %0d cycles, required 1", axi_arready_o, k);
    end
    @(posedge clk_i); #1;
    axi_arvalid_i = 0;
  endtask

  // Beat i uses strobe nibble i of strbs (beats past 3 reuse nibble 3)
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [15:0] strbs,
                           input logic [31:0] base, input int err_beat);
    logic [31:0] a;
    logic [3:0]  s;
    logic        any_err;
    bexp_t       be;
    int          k;
    a = addr; any_err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      s = (i < 4) ? strbs[i*4 +: 4] : strbs[15:12];
      if (s != 4'h0) begin
        mq.push_back('{a, 1'b0, s, base + 32'(i), 32'd0, (i == err_beat)});
        if (i == err_beat) any_err = 1;
      end
      a = nxt_addr(a, len, burst);
    end
    bq.push_back('{(any_err ? 2'b10 : 2'b00), id});
    do_aw(addr, id, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      axi_wdata_i = base + 32'(i);
      axi_wstrb_i = (i < 4) ? strbs[i*4 +: 4] : strbs[15:12];
      axi_wlast_i = (i == int'(len));
      axi_wvalid_i = 1;
      k = 0;
      while (!axi_wready_o && k < 100) begin @(posedge clk_i); #1; k++; end
      if (!axi_wready_o) begin
        n_vec++; n_err++; axi_wvalid_i = 0;
        $display("FAIL w_timeout: wready=%0b at beat %0d, required 1", axi_wready_o, i);
        mq.delete(); bq.delete();
        return;
      end
      @(posedge clk_i); #1;
      axi_wvalid_i = 0;
    end
    k = 0;
    while (!axi_bvalid_o && k < 100) begin @(posedge clk_i); #1; k++; end
    n_vec++;
    if (!axi_bvalid_o || bq.size() == 0) begin
      n_err++; $display("FAIL b_timeout: bvalid=%0b, required 1", axi_bvalid_o);
      mq.delete(); bq.delete();
      return;
    end
    be = bq.pop_front();
    if ($urandom_range(0, 1) == 1) begin @(posedge clk_i); #1; end
    if ({axi_bvalid_o, axi_bresp_o, axi_bid_o} !== {1'b1, be.resp, be.id}) begin
      n_err++;
      $display("FAIL b_resp: bvalid=%0b bresp=%b bid=%h, required 1 %b %h",
               axi_bvalid_o, axi_bresp_o, axi_bid_o, be.resp, be.id);
    end
    axi_bready_i = 1;
    @(posedge clk_i); #1;
    axi_bready_i = 0;
    n_vec++;
    if (mq.size() != 0 || axi_bvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL w_drain: pending mem=%0d bvalid=%0b, required 0 0", mq.size(), axi_bvalid_o);
      mq.delete();
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] base, input int err_beat);
    logic [31:0] a;
    rbeat_t      e;
    int          k, st;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      mq.push_back('{a, 1'b1, 4'h0, 32'd0, base + 32'(i), (i == err_beat)});
      rq.push_back('{base + 32'(i), ((i == err_beat) ? 2'b10 : 2'b00), id, (i == int'(len))});
      a = nxt_addr(a, len, burst);
    end
    do_ar(addr, id, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      k = 0;
      while (!axi_rvalid_o && k < 100) begin @(posedge clk_i); #1; k++; end
      if (!axi_rvalid_o) begin
        n_vec++; n_err++;
        $display("FAIL r_timeout: rvalid=%0b at beat %0d, required 1", axi_rvalid_o, i);
        mq.delete(); rq.delete();
        return;
      end
      e = rq.pop_front();
      st = (i == 0) ? 2 : $urandom_range(0, 2);
      for (int s = 0; s <= st; s++) begin
        n_vec++;
        if ({axi_rvalid_o, axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o} !==
            {1'b1, e.data, e.resp, e.id, e.last}) begin
          n_err++;
          $display("FAIL r_beat%0d: valid=%0b data=%h resp=%b id=%h last=%0b, required 1 %h %b %h %0b",
                   i, axi_rvalid_o, axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o,
                   e.data, e.resp, e.id, e.last);
        end
        if (s == st) axi_rready_i = 1;
        @(posedge clk_i); #1;
        axi_rready_i = 0;
      end
    end
    n_vec++;
    if (mq.size() != 0 || axi_rvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL r_drain: pending mem=%0d rvalid=%0b, required 0 0", mq.size(), axi_rvalid_o);
      mq.delete();
    end
  endtask

  task automatic test_reset;
    rst_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++;
    if ({axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, mem_rd_o, mem_wr_o}
        !== 10'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: aw=%0b ar=%0b w=%0b b=%0b r=%0b rd=%0b wr=%h, required all 0",
               axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o,
               mem_rd_o, mem_wr_o);
    end
    n_vec++;
    if ({mem_addr_o, mem_data_wr_o, axi_rdata_o, axi_rresp_o, axi_bresp_o, axi_rid_o, axi_bid_o,
         axi_rlast_o} !== 81'd0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h wd=%h rd=%h rresp=%b bresp=%b, required 0",
               mem_addr_o, mem_data_wr_o, axi_rdata_o, axi_rresp_o, axi_bresp_o);
    end
    n_vec++;
    if ({mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o, mem_req_tag_o} !== 15'd0)
    begin
      n_err++; $display("FAIL tied_zero: got %h required 0",
                        {mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o, mem_req_tag_o});
    end
    @(posedge clk_i); #1;
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_single_write;
    axi_write(32'h0000_1000, 4'h3, 8'd0, 2'b01, 16'h000F, 32'hDEAD_BEEF, -1);
  endtask

  task automatic test_incr_read;
    axi_read(32'h0000_2000, 4'h5, 8'd3, 2'b01, 32'd0, -1);
  endtask

  task automatic test_wrap_read;
    axi_read(32'h0000_100C, 4'h1, 8'd3, 2'b10, 32'h0000_00A0, 2);
  endtask

  task automatic test_error_strobe;
    axi_write(32'h0000_3000, 4'h6, 8'd1, 2'b01, 16'h000F, 32'hA5A5_0000, 0);
    axi_write(32'h0000_3100, 4'h7, 8'd0, 2'b01, 16'h0003, 32'h1234_5678, -1);
  endtask

  task automatic test_burst_modes;
    axi_read(32'h0000_4004, 4'h2, 8'd1, 2'b00, 32'h0000_0B00, -1);
    axi_write(32'hFFFF_FFFC, 4'h4, 8'd1, 2'b11, 16'h00C3, 32'h0F0F_0000, -1);
    axi_write(32'h0000_9008, 4'h8, 8'd1, 2'b10, 16'h00FF, 32'h7700_0000, -1);
  endtask

  task automatic test_long_bursts;
    axi_write(32'h0000_A000, 4'hC, 8'd255, 2'b01, 16'h0000, 32'h0, -1);
    axi_read(32'h0000_0000, 4'hD, 8'd255, 2'b01, 32'h0001_0000, 200);
  endtask

  task automatic test_back_to_back;
    axi_write(32'h0000_5500, 4'hE, 8'd2, 2'b01, 16'h0F8F, 32'h0BAD_0000, 1);
    axi_read(32'h0000_5500, 4'hF, 8'd0, 2'b01, 32'h0000_CAFE, -1);
    axi_write(32'h0000_5600, 4'h0, 8'd0, 2'b00, 16'h000F, 32'h600D_0001, -1);
  endtask

  task automatic test_arbitration;
    logic exp_w [4];
    int   grants, k;
    rbeat_t e;
    bexp_t  be;
    exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0; exp_w[3] = 1;
    rst_i = 0;
    axi_awaddr_i = 32'h6000; axi_awid_i = 4'hA; axi_awlen_i = 0; axi_awburst_i = 2'b01;
    axi_araddr_i = 32'h5000; axi_arid_i = 4'hB; axi_arlen_i = 0; axi_arburst_i = 2'b01;
    axi_awvalid_i = 1; axi_arvalid_i = 1;
    axi_wvalid_i = 1; axi_wstrb_i = 4'h0; axi_wdata_i = 32'h0; axi_wlast_i = 1;
    axi_rready_i = 1; axi_bready_i = 1;
    for (int i = 0; i < 2; i++) begin
      mq.push_back('{32'h5000, 1'b1, 4'h0, 32'd0, 32'h11 * 32'(i + 1), 1'b0});
      rq.push_back('{32'h11 * 32'(i + 1), 2'b00, 4'hB, 1'b1});
      bq.push_back('{2'b00, 4'hA});
    end
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++;
    if ({axi_awready_o, axi_arready_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: aw=%0b ar=%0b, required 0 0", axi_awready_o, axi_arready_o);
    end
    rst_i = 1; #1;
    grants = 0; k = 0;
    while ((grants < 4 || rq.size() != 0 || bq.size() != 0) && k < 300) begin
      if ((axi_awready_o || axi_arready_o) && grants < 4) begin
        n_vec++;
        if ({axi_awready_o, axi_arready_o} !== {exp_w[grants], !exp_w[grants]}) begin
          n_err++;
          $display("FAIL arb_grant%0d: aw=%0b ar=%0b, required aw=%0b ar=%0b", grants,
                   axi_awready_o, axi_arready_o, exp_w[grants], !exp_w[grants]);
        end
        grants++;
      end
      if (axi_rvalid_o && rq.size() != 0) begin
        e = rq.pop_front();
        n_vec++;
        if ({axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o} !== {e.data, e.resp, e.id, e.last}) begin
          n_err++;
          $display("FAIL arb_r: data=%h resp=%b id=%h last=%0b, required %h %b %h %0b",
                   axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o, e.data, e.resp, e.id, e.last);
        end
      end
      if (axi_bvalid_o && bq.size() != 0) begin
        be = bq.pop_front();
        n_vec++;
        if ({axi_bresp_o, axi_bid_o} !== {be.resp, be.id}) begin
          n_err++;
          $display("FAIL arb_b: bresp=%b bid=%h, required %b %h", axi_bresp_o, axi_bid_o, be.resp, be.id);
        end
      end
      @(posedge clk_i); #1;
      if (grants >= 4) begin axi_awvalid_i = 0; axi_arvalid_i = 0; end
      k++;
    end
    n_vec++;
    if (grants != 4 || rq.size() != 0 || bq.size() != 0 || mq.size() != 0) begin
      n_err++;
      $display("FAIL arb_done: grants=%0d r=%0d b=%0d mem=%0d, required 4 0 0 0",
               grants, rq.size(), bq.size(), mq.size());
      rq.delete(); bq.delete(); mq.delete();
    end
    axi_awvalid_i = 0; axi_arvalid_i = 0; axi_wvalid_i = 0; axi_rready_i = 0; axi_bready_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid_burst;
    int k;
    hold_ack = 1;
    mq.push_back('{32'h7000, 1'b1, 4'h0, 32'd0, 32'h77, 1'b0});
    do_ar(32'h0000_7000, 4'h2, 8'd3, 2'b01);
    k = 0;
    while (!(mq.size() == 0 && !mem_rd_o) && k < 50) begin @(posedge clk_i); #1; k++; end
    n_vec++;
    if (mq.size() != 0 || mem_rd_o) begin
      n_err++; $display("FAIL mid_accept: pending=%0d rd=%0b, required 0 0", mq.size(), mem_rd_o);
      mq.delete();
    end
    @(posedge clk_i); #2;
    rst_i = 0; #1;
    n_vec++;
    if ({axi_rvalid_o, axi_bvalid_o, axi_wready_o, axi_arready_o, axi_awready_o, mem_rd_o,
         mem_wr_o, mem_addr_o} !== 42'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: r=%0b rd=%0b wr=%h addr=%h, required 0",
               axi_rvalid_o, mem_rd_o, mem_wr_o, mem_addr_o);
    end
    @(posedge clk_i); #1;
    n_vec++;
    if ({axi_rvalid_o, axi_rdata_o, axi_rlast_o, mem_rd_o, mem_wr_o} !== 39'd0) begin
      n_err++;
      $display("FAIL mid_reset_edge: r=%0b data=%h last=%0b rd=%0b wr=%h, required 0",
               axi_rvalid_o, axi_rdata_o, axi_rlast_o, mem_rd_o, mem_wr_o);
    end
    hold_ack = 0;
    @(posedge clk_i); #1;
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++;
    if ({axi_rvalid_o, mem_rd_o} !== 2'b00) begin
      n_err++; $display("FAIL mid_resume: rvalid=%0b rd=%0b, required 0 0", axi_rvalid_o, mem_rd_o);
    end
    axi_read(32'h0000_8000, 4'h9, 8'd0, 2'b01, 32'h0000_0055, -1);
  endtask

  initial begin
    rst_i = 0;
    axi_awvalid_i = 0; axi_awaddr_i = 0; axi_awid_i = 0; axi_awlen_i = 0; axi_awburst_i = 0;
    axi_wvalid_i = 0; axi_wdata_i = 0; axi_wstrb_i = 0; axi_wlast_i = 0; axi_bready_i = 0;
    axi_arvalid_i = 0; axi_araddr_i = 0; axi_arid_i = 0; axi_arlen_i = 0; axi_arburst_i = 0;
    axi_rready_i = 0;
    test_reset;
    test_single_write;
    test_incr_read;
    test_wrap_read;
    test_error_strobe;
    test_burst_modes;
    test_long_bursts;
    test_back_to_back;
    test_arbitration;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dport_axi_slave.md
DPORT_AXI_SLAVE -- requirements
Module: dport_axi_slave

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset:
  - clk_i  in  1  clock
  - rst_i  in  1  reset, asynchronous, active-low
REQ-002 SHALL have the following AXI4 slave ports:
  - axi_awvalid_i in 1, axi_awaddr_i in 32, axi_awid_i in 4, axi_awlen_i in 8, axi_awburst_i in 2, axi_awready_o out 1: write address channel
  - axi_wvalid_i in 1, axi_wdata_i in 32, axi_wstrb_i in 4, axi_wlast_i in 1, axi_wready_o out 1: write data channel
  - axi_bvalid_o out 1, axi_bresp_o out 2, axi_bid_o out 4, axi_bready_i in 1: write response channel
  - axi_arvalid_i in 1, axi_araddr_i in 32, axi_arid_i in 4, axi_arlen_i in 8, axi_arburst_i in 2, axi_arready_o out 1: read address channel
  - axi_rvalid_o out 1, axi_rdata_o out 32, axi_rresp_o out 2, axi_rid_o out 4, axi_rlast_o out 1, axi_rready_i in 1: read data channel
REQ-003 SHALL have the following dcache_if-style memory initiator ports:
  - mem_addr_o out 32, mem_data_wr_o out 32, mem_rd_o out 1, mem_wr_o out 4: request
  - mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o: out 1 each, tied 0
  - mem_req_tag_o out 11, tied 0
  - mem_accept_i in 1, mem_ack_i in 1, mem_error_i in 1, mem_data_rd_i in 32: accept and response
  - mem_resp_tag_i in 11: ignored

Function
REQ-004 SHALL implement an FSM with states IDLE, WDATA, WREQ, WACK, BRESP, RREQ, RACK, RRESP, and SHALL allow one AXI transaction and at most one memory request outstanding.
REQ-005 In IDLE:
  - axi_awready_o SHALL equal the write grant; axi_arready_o SHALL equal the read grant.
  - Both channels valid: grant SHALL go to the channel not granted last; the first grant after reset SHALL go to read.
  - On grant, SHALL latch addr, id, len and burst.
  - Write grant SHALL go to WDATA; read grant SHALL go to RREQ.
REQ-006 In WDATA:
  - axi_wready_o SHALL be 1.
  - On wvalid, SHALL latch wdata/wstrb and go to WREQ.
  - If wstrb==0, SHALL skip memory and treat the beat as OKAY (advance directly as if acked).
REQ-007 In WREQ/RREQ:
  - mem_wr_o=wstrb (or mem_rd_o=1) with mem_addr_o={addr[31:2],2'b00} SHALL be held stable until mem_accept_i=1.
  - Then SHALL go to WACK/RACK.
  - Request SHALL be asserted the cycle after the grant or wdata capture.
REQ-008 In WACK, on mem_ack_i:
  - mem_error_i SHALL be ORed into a sticky error flag.
  - If beat counter == len, SHALL go to BRESP; else SHALL advance the address and return to WDATA.
REQ-009 BRESP:
  - axi_bvalid_o=1, axi_bid_o=latched id, axi_bresp_o=2'b10 if sticky error else 2'b00.
  - Held until axi_bready_i; then SHALL clear sticky error and go to IDLE.
REQ-010 In RACK, on mem_ack_i, SHALL capture mem_data_rd_i and per-beat rresp (2'b10 if mem_error_i else 2'b00), then go to RRESP.
REQ-011 RRESP:
  - axi_rvalid_o=1, axi_rid_o=latched id, axi_rlast_o=(beat==len).
  - Data and response SHALL be held stable until axi_rready_i.
  - Then SHALL go to IDLE if last, else advance the address and go to RREQ.
REQ-012 Address advance:
  - FIXED (00): SHALL keep the address.
  - INCR (01): SHALL add 4, wrapping mod 2^32.
  - WRAP (10): SHALL add 4 within a (len+1)*4-byte aligned window, lower bits wrapping.
  - Burst 11: SHALL be treated as INCR.
REQ-013 Beat counter SHALL be 8 bits, cleared on grant, incremented per completed beat; len=255 yields 256 beats.
REQ-014 axi_wlast_i SHALL be ignored; beat count SHALL be governed solely by the latched len.
REQ-015 mem_ack_i outside WACK/RACK SHALL be ignored; mem_ack_i in the same cycle as mem_accept_i SHALL NOT occur (single outstanding, ack at least one cycle after accept).
REQ-016 All outputs SHALL be registered, except axi_awready_o/axi_arready_o, which are combinational from IDLE state and valid inputs.

Reset
REQ-017 While rst_i=0:
  - state SHALL be IDLE.
  - All valid/ready outputs, mem_rd_o and mem_wr_o SHALL be 0.
  - Address, data, id, resp, counter, sticky error and priority SHALL be 0 (read preferred).
REQ-018 Reset asserted mid-transaction SHALL abandon it immediately with no further memory request or AXI response; after deassertion SHALL start in IDLE.

Verification
REQ-019 Single write: AW addr 0x1000 len 0, W 0xDEADBEEF strb 0xF; mem accept +1, ack +2 -> mem_wr_o=0xF at addr 0x1000; bvalid bresp 00 bid=AW id.
REQ-020 INCR read: AR 0x2000 len 3 id 5; mem returns 0..3 -> four R beats data 0..3, addresses 0x2000..0x200C, rlast only on beat 4, rid 5; rready stalls hold data stable.
REQ-021 WRAP read: AR 0x100C len 3 -> addresses 0x100C, 0x1000, 0x1004, 0x1008.
REQ-022 Error and strobe: 2-beat write, beat 1 mem_error_i=1, beat 2 strb 0 -> only one mem request issued; bresp 2'b10.
REQ-023 Arbitration: awvalid and arvalid both high continuously from reset -> grants alternate read, write, read, write.
REQ-024 Reset mid-burst: rst_i low during RACK -> all outputs 0 next edge; new AR after release completes normally.
